// File: rtl/winit_pkg.sv
// rtl/winit_pkg.sv - shared state encoding and PRNG range constants for rand_weight_init
package winit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] RAND_MAX    = 32'h0100_0000;
  localparam logic [31:0] RAND_CENTER = 32'h0080_0000;

endpackage

// File: rtl/winit_scale.sv
// rtl/winit_scale.sv - combinational clamp/centre/shift/reduce of a PRNG word to a signed weight
// WINIT_SAT_EN selects saturation instead of two's-complement wrap on the final reduction.
module winit_scale
  import winit_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SCALE_SHIFT = 10
) (
  input  logic [31:0]       rand_in,
  output logic [DATA_W-1:0] weight
);

  // Wide enough for the centred value and for any requested weight width.
  localparam int SW = (DATA_W > 26) ? DATA_W : 26;

  logic [24:0]          r;
  logic signed [25:0]   c;
  logic signed [SW-1:0] s;

  assign r = (rand_in > RAND_MAX) ? RAND_MAX[24:0] : rand_in[24:0];
  assign c = $signed({1'b0, r}) - $signed({1'b0, RAND_CENTER[24:0]});
  assign s = SW'(c) >>> SCALE_SHIFT;

`ifdef WINIT_SAT_EN
  localparam logic signed [SW-1:0] W_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] W_MIN = ~W_MAX;

  always_comb begin
    weight = DATA_W'(s);
    if (s > W_MAX) begin
      weight = DATA_W'(W_MAX);
    end else if (s < W_MIN) begin
      weight = DATA_W'(W_MIN);
    end
  end
`else
  assign weight = DATA_W'(s);
`endif

endmodule

// File: rtl/rand_weight_init.sv
// rtl/rand_weight_init.sv - fetches N_WEIGHTS PRNG words and writes centred, scaled weights to RAM
// Optional saturation of the weight is enabled by defining WINIT_SAT_EN (see winit_scale).
module rand_weight_init
  import winit_pkg::*;
#(
  parameter int N_WEIGHTS   = 64,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int SCALE_SHIFT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       rand_in,
  input  logic              rand_valid,
  output logic              rand_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              w_we,
  output logic              busy,
  output logic              done
);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   weight;
  logic                last;

  winit_scale #(
    .DATA_W      (DATA_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_scale (
    .rand_in (rand_in),
    .weight  (weight)
  );

  assign last = (cnt == ADDR_W'(N_WEIGHTS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rand_ready = 1'b0;
    w_we       = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        rand_ready = 1'b1;
        if (rand_valid) state_next = WRITE;
      end
      WRITE: begin
        w_we       = 1'b1;
        state_next = last ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The weight is latched at the handshake so w_data stays put through the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      wdata <= '0;
    end else begin
      if (state == IDLE && start) cnt <= '0;
      if (state == FETCH && rand_valid) wdata <= weight;
      if (state == WRITE && !last) cnt <= cnt + 1'b1;
    end
  end

  assign w_addr = cnt;
  assign w_data = wdata;

endmodule

// File: tb/tb_rand_weight_init.sv
// tb/tb_rand_weight_init.sv - self-checking bench for rand_weight_init (reference model plus directed runs)
module tb_rand_weight_init;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rand_in = 32'h0;
  logic        rand_valid = 1'b0;
  logic        rand_ready;
  logic [5:0]  w_addr;
  logic [15:0] w_data;
  logic        w_we;
  logic        busy;
  logic        done;

  logic        start_b = 1'b0;
  logic [31:0] rand_in_b = 32'h0;
  logic        valid_b = 1'b0;
  logic        ready_b;
  logic [0:0]  w_addr_b;
  logic [15:0] w_data_b;
  logic        w_we_b;
  logic        busy_b;
  logic        done_b;

  rand_weight_init #(.N_WEIGHTS(NW), .ADDR_W(6), .DATA_W(16), .SCALE_SHIFT(10)) dut (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .w_addr(w_addr), .w_data(w_data), .w_we(w_we),
    .busy(busy), .done(done)
  );

  rand_weight_init #(.N_WEIGHTS(2), .ADDR_W(1), .DATA_W(16), .SCALE_SHIFT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rand_in(rand_in_b), .rand_valid(valid_b),
    .rand_ready(ready_b), .w_addr(w_addr_b), .w_data(w_data_b), .w_we(w_we_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Weight mapping from plain integer arithmetic: clamp, centre, floor-divide, reduce.
  function automatic logic [15:0] model_map(input logic [31:0] x, input int sh);
    longint r, c, d, s;
    r = (longint'(x) > 64'sd16777216) ? 64'sd16777216 : longint'(x);
    c = r - 64'sd8388608;
    d = longint'(1) << sh;
    s = (c >= 0) ? (c / d) : -((-c + d - 1) / d);
`ifdef WINIT_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  // Reference model: 0 idle, 1 waiting for a word, 2 writing, 3 finished.
  int          m_mode = 0;
  int          m_idx = 0;
  logic [15:0] m_wt = 16'h0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_idx  = 0;
      m_wt   = 16'h0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_idx = 0; end
        1: if (rand_valid) begin m_wt = model_map(rand_in, 10); m_mode = 2; end
        2: if (m_idx == NW - 1) m_mode = 3; else begin m_idx++; m_mode = 1; end
        default: m_mode = 0;
      endcase
    end
  end

  int          log_cnt = 0;
  int          done_cnt = 0;
  logic [5:0]  log_addr [0:63];
  logic [15:0] log_data [0:63];

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("rand_ready", 32'(rand_ready), 32'(m_mode == 1));
      chk("w_we", 32'(w_we), 32'(m_mode == 2));
      chk("w_addr", 32'(w_addr), 32'(m_idx));
      chk("w_data", 32'(w_data), 32'(m_wt));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("done", 32'(done), 32'(m_mode == 3));
      if (w_we && log_cnt < 64) begin
        log_addr[log_cnt] = w_addr;
        log_data[log_cnt] = w_data;
        log_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  int          logb_cnt = 0;
  logic [15:0] logb [0:1];

  always @(negedge clk) begin
    if (cyc > 0 && w_we_b) begin
      logb[w_addr_b] = w_data_b;
      logb_cnt++;
    end
  end

  // Word feeder for the main instance; optionally drops rand_valid at random.
  logic [31:0] words [$];
  bit          toggle_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst && rand_valid && rand_ready && words.size() > 0) void'(words.pop_front());
    #1;
    if (words.size() > 0 && (!toggle_valid || $urandom_range(1, 0) == 1)) begin
      rand_valid = 1'b1;
      rand_in    = words[0];
    end else begin
      rand_valid = 1'b0;
      rand_in    = $urandom;
    end
  end

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_b();
    logic [31:0] wb [0:1];
    logic [15:0] exp_b [0:1];
    bit          got;
    wb[0] = 32'h0100_0000;
    wb[1] = 32'h0000_0000;
`ifdef WINIT_SAT_EN
    exp_b[0] = 16'h7FFF;
    exp_b[1] = 16'h8000;
`else
    exp_b[0] = 16'h0000;
    exp_b[1] = 16'h0000;
`endif
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_in_b = wb[i];
      valid_b   = 1'b1;
      got       = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(posedge clk);
        if (ready_b) begin
          got = 1'b1;
          break;
        end
      end
      #1;
      if (!got) chk("shift4_handshake_timeout", 32'd0, 32'd1);
    end
    valid_b = 1'b0;
    got = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done_b) begin
        got = 1'b1;
        break;
      end
    end
    chk("shift4_done", 32'(got), 32'd1);
    chk("shift4_writes", 32'(logb_cnt), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk("shift4_literal", 32'(logb[i]), 32'(exp_b[i]));
      chk("shift4_model", 32'(logb[i]), 32'(model_map(wb[i], 4)));
    end
  endtask

  initial begin
    int t0;
    int dcyc;
    logic [15:0] exp1 [0:3];

    chk("model_map_zero", 32'(model_map(32'h0, 10)), 32'h0000_E000);
    chk("model_map_over", 32'(model_map(32'hFFFF_FFFF, 10)), 32'h0000_2000);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rand_ready", 32'(rand_ready), 32'd0);
    chk("reset_w_we", 32'(w_we), 32'd0);
    chk("reset_w_addr", 32'(w_addr), 32'd0);
    chk("reset_w_data", 32'(w_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    run_b();

    // Run 1: rand_valid held high, boundary words, start held through DONE.
    @(negedge clk);
    log_cnt  = 0;
    done_cnt = 0;
    words = {32'h0000_0000, 32'h0080_0000, 32'h0100_0000, 32'hFFFF_FFFF};
    exp1[0] = 16'hE000;
    exp1[1] = 16'h0000;
    exp1[2] = 16'h2000;
    exp1[3] = 16'h2000;
    pulse_start(t0);
    wait_done("run1_done", dcyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run1_done_cycle", 32'(dcyc - t0 + 1), 32'd10);
    @(negedge clk);
    chk("run1_busy_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("run1_start_in_done_ignored", 32'(busy), 32'd0);
    chk("run1_write_count", 32'(log_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("run1_addr", 32'(log_addr[i]), 32'(i));
      chk("run1_data", 32'(log_data[i]), 32'(exp1[i]));
    end

    // Run 2: rand_valid toggled at random.
    @(negedge clk);
    log_cnt = 0;
    toggle_valid = 1'b1;
    words = {32'h0012_3456, 32'h00FF_FFFF, 32'h0200_0000, 32'h0000_07FF};
    pulse_start(t0);
    wait_done("run2_done", dcyc);
    toggle_valid = 1'b0;
    @(negedge clk);
    chk("run2_write_count", 32'(log_cnt), 32'd4);

    // Run 3: reset during the third FETCH, then a clean restart.
    @(negedge clk);
    log_cnt  = 0;
    done_cnt = 0;
    words = {32'h0040_0000, 32'h00C0_0000, 32'h0060_0000, 32'h00A0_0000};
    pulse_start(t0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rand_ready", 32'(rand_ready), 32'd0);
    chk("midrst_w_we", 32'(w_we), 32'd0);
    chk("midrst_w_addr", 32'(w_addr), 32'd0);
    chk("midrst_w_data", 32'(w_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_partial_writes", 32'(log_cnt), 32'd2);
    repeat (10) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_no_more_writes", 32'(log_cnt), 32'd2);

    words.delete();
    log_cnt = 0;
    words = {32'h0010_0000, 32'h00F0_0000, 32'h0080_0001, 32'h007F_FFFF};
    pulse_start(t0);
    wait_done("restart_done", dcyc);
    @(negedge clk);
    chk("restart_write_count", 32'(log_cnt), 32'd4);
    chk("restart_first_addr", 32'(log_addr[0]), 32'd0);
    chk("restart_data0", 32'(log_data[0]), 32'h0000_E400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
